// File: rtl/ai_paddle_ctrl.sv
// ai_paddle_ctrl: computer opponent driving a paddle's 2-bit left/right command.
// Once per frame it samples the ball and paddle positions. After a reaction
// delay it registers a move toward the ball, or toward screen centre when the
// ball is receding.
// Optional feature: define AI_MISS_EN to add LFSR-driven hesitation (00 command).
module ai_paddle_ctrl #(
  parameter int D_WIDTH       = 640,
  parameter int DEADBAND      = 8,
  parameter int REACT_FRAMES  = 3,
  parameter int CNT_W         = 4,
  parameter int APPROACH_DOWN = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ani_stb,
  input  logic        i_animate,
  input  logic [11:0] i_ball_x,
  input  logic [11:0] i_ball_y,
  input  logic [11:0] i_pad_x1,
  input  logic [11:0] i_pad_x2,
  output logic [1:0]  o_btn_lr,
  output logic        o_decide
);

  typedef enum logic [1:0] {IDLE, WAIT, DECIDE} state_t;

  localparam logic [11:0]        CENTRE_X = 12'(D_WIDTH / 2);
  localparam logic [11:0]        RIGHT_LIM = 12'(D_WIDTH);
  localparam logic signed [13:0] DB = 14'(DEADBAND);
  localparam logic [CNT_W-1:0]   REACT = CNT_W'(REACT_FRAMES);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [11:0]      prev_y;
  logic             appr;
  logic             fe;
  logic [1:0]       btn_nx;
  logic             decide_nx;

  logic [12:0]        centre_sum;
  logic [11:0]        centre;
  logic [11:0]        target;
  logic signed [13:0] err;
  logic [1:0]         cmd;

  assign fe = i_ani_stb & i_animate;

`ifdef AI_MISS_EN
  logic [7:0] lfsr;

  // Hesitation source: Fibonacci LFSR (taps 8,6,5,4) stepping on frames outside IDLE
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr <= 8'hA5;
    end else if (fe && state != IDLE) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end
`endif

  // State register; animate low forces IDLE without touching counter/flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else if (!i_animate) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; a strobe landing in DECIDE is ignored
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (fe) state_nx = WAIT;
      WAIT:    if (fe && cnt == '0) state_nx = DECIDE;
      DECIDE:  state_nx = WAIT;
      default: state_nx = IDLE;
    endcase
  end

  // Reaction counter, previous ball y and approach flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt    <= '0;
      prev_y <= '0;
      appr   <= 1'b0;
    end else if (i_animate) begin
      unique case (state)
        IDLE: begin
          if (fe) begin
            prev_y <= i_ball_y;
            cnt    <= REACT;
          end
        end
        WAIT: begin
          if (fe) begin
            prev_y <= i_ball_y;
            if (i_ball_y > prev_y)      appr <= (APPROACH_DOWN != 0);
            else if (i_ball_y < prev_y) appr <= (APPROACH_DOWN == 0);
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
        end
        DECIDE:  cnt <= REACT;
        default: cnt <= REACT;
      endcase
    end
  end

  // Steering command from target error, deadband and edge gating
  always_comb begin
    centre_sum = {1'b0, i_pad_x1} + {1'b0, i_pad_x2};
    centre     = centre_sum[12:1];
    target     = appr ? i_ball_x : CENTRE_X;
    err        = signed'({2'b00, target}) - signed'({2'b00, centre});
    cmd        = 2'b00;
    if (err > DB)        cmd = 2'b01;
    else if (err < -DB)  cmd = 2'b10;
    if (i_pad_x2 > RIGHT_LIM) cmd[0] = 1'b0;
    if (i_pad_x1 < 12'd2)     cmd[1] = 1'b0;
`ifdef AI_MISS_EN
    if (lfsr[2:0] == 3'b000) cmd = 2'b00;
`endif
  end

  // Output decode: new command only in DECIDE, cleared in IDLE, held otherwise
  always_comb begin
    btn_nx    = o_btn_lr;
    decide_nx = 1'b0;
    unique case (state)
      IDLE:   btn_nx = 2'b00;
      WAIT:   btn_nx = o_btn_lr;
      DECIDE: begin
        btn_nx    = cmd;
        decide_nx = 1'b1;
      end
      default: btn_nx = 2'b00;
    endcase
  end

  // Registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_animate) begin
      o_btn_lr <= 2'b00;
      o_decide <= 1'b0;
    end else begin
      o_btn_lr <= btn_nx;
      o_decide <= decide_nx;
    end
  end

endmodule

// File: tb/tb_ai_paddle_ctrl.sv
// Self-checking bench for ai_paddle_ctrl: directed scenarios followed by random
// frames, all checked cycle by cycle against a frame-counting reference model.
module tb_ai_paddle_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst, i_ani_stb, i_animate;
  logic [11:0] i_ball_x, i_ball_y, i_pad_x1, i_pad_x2;
  logic [1:0]  o_btn_lr;
  logic        o_decide;

  always #5 i_clk = ~i_clk;

  ai_paddle_ctrl #(
    .D_WIDTH(640), .DEADBAND(8), .REACT_FRAMES(3), .CNT_W(4), .APPROACH_DOWN(1)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_animate(i_animate),
    .i_ball_x(i_ball_x), .i_ball_y(i_ball_y), .i_pad_x1(i_pad_x1), .i_pad_x2(i_pad_x2),
    .o_btn_lr(o_btn_lr), .o_decide(o_decide)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: frames seen since leaving idle, last y, approach flag
  bit         m_idle = 1'b1;
  int         m_n    = 0;
  int         m_prev = 0;
  bit         m_appr = 1'b0;
  bit         m_pend = 1'b0;
  logic [1:0] m_btn  = 2'b00;
  logic       m_dec  = 1'b0;
  int         m_lfsr = 'hA5;

  function automatic logic [1:0] ref_cmd();
    int target, centre, err;
    logic [1:0] c;
    target = m_appr ? int'(i_ball_x) : 320;
    centre = (int'(i_pad_x1) + int'(i_pad_x2)) / 2;
    err    = target - centre;
    c = (err > 8) ? 2'b01 : (err < -8) ? 2'b10 : 2'b00;
    if (int'(i_pad_x2) > 640 && c == 2'b01) c = 2'b00;
    if (int'(i_pad_x1) < 2 && c == 2'b10)   c = 2'b00;
    return c;
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: apply controls, advance the model at the edge, check after it
  task automatic step(input bit stb, input bit anim, input bit rst);
    int fb;
    i_ani_stb = stb;
    i_animate = anim;
    i_rst     = rst;
    @(posedge i_clk);
    if (rst) begin
      m_idle = 1; m_appr = 0; m_prev = 0; m_pend = 0;
      m_btn = 2'b00; m_dec = 0; m_lfsr = 'hA5;
    end else if (!anim) begin
      m_idle = 1; m_pend = 0; m_btn = 2'b00; m_dec = 0;
    end else begin
      m_dec = 0;
      if (m_pend) begin
        m_btn = ref_cmd();
`ifdef AI_MISS_EN
        if ((m_lfsr & 7) == 0) m_btn = 2'b00;
`endif
        m_dec  = 1;
        m_pend = 0;
        m_n    = 1;
      end else if (stb) begin
        if (m_idle) begin
          m_idle = 0;
          m_n    = 1;
          m_prev = int'(i_ball_y);
        end else begin
          fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
          m_lfsr = ((m_lfsr << 1) | fb) & 255;
          if (int'(i_ball_y) > m_prev)      m_appr = 1;
          else if (int'(i_ball_y) < m_prev) m_appr = 0;
          m_prev = int'(i_ball_y);
          m_n++;
          if (m_n == 5) m_pend = 1;
        end
      end
    end
    #1;
    check("btn_lr", o_btn_lr, m_btn);
    check("decide", {1'b0, o_decide}, {1'b0, m_dec});
    check("btn_not_11", {1'b0, o_btn_lr == 2'b11}, 2'b00);
    i_ani_stb = 1'b0;
    i_animate = 1'b1;
    i_rst     = 1'b0;
  endtask

  // One animation frame: positions set, strobe, then three quiet cycles
  task automatic frame(input int bx, input int by, input int x1, input int x2, input bit anim);
    i_ball_x = 12'(bx);
    i_ball_y = 12'(by);
    i_pad_x1 = 12'(x1);
    i_pad_x2 = 12'(x2);
    step(1'b1, anim, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int y, dir, bx, x1, r;
    i_rst = 1'b1; i_ani_stb = 1'b0; i_animate = 1'b1;
    i_ball_x = '0; i_ball_y = '0; i_pad_x1 = 12'd290; i_pad_x2 = 12'd350;

    // Reset state
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 1, 0);

    // Track right: ball approaching, paddle centred at 320
    y = 100;
    for (int i = 0; i < 11; i++) begin
      frame(400, y, 290, 350, 1);
      y += 4;
    end

    // Reset in WAIT while commanding right, then restart
    step(0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      frame(400, y, 290, 350, 1);
      y += 4;
    end

    // Deadband edges: err 8 gives no move, err -9 moves left
    for (int i = 0; i < 4; i++) begin frame(328, y, 290, 350, 1); y += 4; end
    for (int i = 0; i < 4; i++) begin frame(311, y, 290, 350, 1); y += 4; end
    for (int i = 0; i < 4; i++) begin frame(400, y, 290, 350, 1); y += 4; end

    // Animation freeze while commanding right, strobes with animate low
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) frame(400, y, 290, 350, 0);

    // Receding ball returns toward centre
    for (int i = 0; i < 9; i++) begin frame(100, y, 470, 530, 1); y -= 3; end
    for (int i = 0; i < 4; i++) begin frame(100, y, 290, 350, 1); y -= 3; end

    // Edge gating on both sides with an approaching ball
    for (int i = 0; i < 8; i++) begin frame(639, y, 585, 645, 1); y += 2; end
    for (int i = 0; i < 4; i++) begin frame(0, y, 1, 61, 1); y += 2; end

    // Random frames with occasional freezes and resets
    y = 240; dir = 1;
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        step(0, 0, 0);
      end else if (r < 5) begin
        step(0, 1, 1);
      end else begin
        if ($urandom_range(0, 7) == 0) dir = -dir;
        y += dir * int'($urandom_range(0, 5));
        if (y < 0) y = 0;
        if (y > 479) y = 479;
        bx = int'($urandom_range(0, 700));
        x1 = int'($urandom_range(0, 620));
        frame(bx, y, x1, x1 + int'($urandom_range(20, 80)), (r < 8) ? 1'b0 : 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
